pipe_ctrl_carrier: RTL and testbench
====================================

Name: pipe_ctrl_carrier

Overview:
Downstream end of the control decoder's output bundle. Captures the decoded ID-stage control word each cycle and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers, with each field retired at its stage. Performs load-use hazard detection (stall plus bubble), branch/jump flush, and EX-operand forwarding selection. Keeps saturating counters of inserted bubbles for performance debug.

Parameters:
REG_W, 5, register-number width
CNT_W, 16, width of the stall and flush counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_alusrc  in  1  decoded ALUSrc
id_regdst  in  1  decoded RegDst
id_aluop  in  3  decoded ALUOp
id_memread  in  1  decoded MemRead
id_memwrite  in  1  decoded MemWrite
id_pcsrc  in  1  decoded PCSrc (branch/jump)
id_regwrite  in  1  decoded RegWrite
id_memtoreg  in  1  decoded MemToReg
id_rs, id_rt, id_rd  in  REG_W  register fields of the ID instruction
ex_taken  in  1  branch/jump resolved taken in EX (from datapath)
ex_alusrc, ex_regdst  out  1  EX-stage controls
ex_aluop  out  3  EX-stage ALU operation
ex_rs, ex_rt  out  REG_W  EX source registers
ex_pcsrc  out  1  EX-stage branch/jump flag
ex_dst  out  REG_W  id_rd if regdst else id_rt, as captured
mem_memread, mem_memwrite  out  1  MEM-stage controls
wb_regwrite, wb_memtoreg  out  1  WB-stage controls
wb_dst  out  REG_W  WB destination register
fwd_a, fwd_b  out  2  operand forward selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
stall  out  1  hold the PC and IF/ID register
if_flush  out  1  squash the IF/ID instruction
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Async reset (rst_n=0): all stage registers clear to a bubble (every control 0, every register field 0); fwd_a/fwd_b=00; stall=0; if_flush=0; counters=0. Reset takes effect mid-stream and discards all in-flight state.
- Pipeline: on each clk edge, ID->EX, EX->MEM and MEM->WB advance together. Each control reaches the stage that consumes it exactly 1, 2 or 3 cycles after ID respectively.
- EX/MEM carries regwrite, memtoreg, memread, memwrite and dst. MEM/WB carries regwrite, memtoreg and dst.
- Load-use: stall = ex_memread & ex_dst!=0 & (ex_dst==id_rs | ex_dst==id_rt). This is combinational in the same cycle.
- When stall is high, the ID/EX capture is a bubble (all controls 0). EX/MEM and MEM/WB still advance. Exactly one bubble is inserted per load-use pair.
- Flush: if_flush = ex_taken. When ex_taken is high, the ID/EX capture is a bubble, which squashes the wrong-path ID instruction.
- ex_taken and a stall condition in the same cycle: flush wins. stall is forced to 0 (the stalled instruction is wrong-path), flush_cnt increments, and stall_cnt does not.
- Forwarding for operand A (fwd_b is the same with ex_rt):
  - 10 if mem_regwrite & mem_dst!=0 & mem_dst==ex_rs;
  - else 01 if wb_regwrite & wb_dst!=0 & wb_dst==ex_rs;
  - else 00.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Counters: stall_cnt increments on each clock edge where stall=1; flush_cnt on each edge where ex_taken=1. Both saturate at all-ones and do not wrap.
- No combinational path from any stage-register output back into that register other than through the hazard logic above.

Test Plan:
- Reset: hold rst_n=0 mid-stream with a non-zero id bundle for 2 cycles -> every output 0. Release -> the id bundle (addi: alusrc=1, regwrite=1, rt=5) appears at ex_* one cycle later, and wb_regwrite=1 with wb_dst=5 three cycles later.
- Load-use: lw rt=8, then add rs=8 -> stall=1 for exactly 1 cycle, EX holds a bubble, stall_cnt=1. The add then enters EX with fwd_a=01 (lw now in WB).
- Forward priority: add dst=3, then sub dst=3, then and rs=3 rt=3 -> in the and's EX cycle, fwd_a=10 and fwd_b=10. A writer with dst=0 -> fwd stays 00.
- Flush: ex_taken=1 for one cycle -> if_flush=1 that cycle, the next ex_* is a bubble, flush_cnt=1.
- Simultaneous: lw rt=4 in EX, id_rs=4, ex_taken=1 -> stall=0, if_flush=1, stall_cnt unchanged, flush_cnt increments.
- Saturation: CNT_W=4, force 20 stalls -> stall_cnt holds 15.

Source files
------------

// File: rtl/pipe_ctrl_carrier.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_carrier
// Description : Carries the decoded ID-stage control word through the ID/EX,
//               EX/MEM and MEM/WB pipeline registers. Each field is retired
//               at the stage that consumes it. Also performs load-use hazard
//               detection (stall + bubble), branch/jump flush, EX-operand
//               forwarding selection, and keeps saturating stall/flush
//               counters for performance debug.
// Ports       :
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_*                          decoded control word and register fields
//   ex_taken                      branch/jump resolved taken in EX
//   ex_alusrc/regdst/aluop/pcsrc  EX-stage controls
//   ex_rs, ex_rt, ex_dst          EX source and destination registers
//   mem_memread, mem_memwrite     MEM-stage controls
//   wb_regwrite, wb_memtoreg      WB-stage controls
//   wb_dst                        WB destination register
//   fwd_a, fwd_b                  operand forward selects (00 RF, 10 EX/MEM,
//                                 01 MEM/WB)
//   stall, if_flush               hazard controls toward IF/ID
//   stall_cnt, flush_cnt          saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_carrier #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic [2:0]       id_aluop,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_pcsrc,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_taken,
  output logic             ex_alusrc,
  output logic             ex_regdst,
  output logic [2:0]       ex_aluop,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic             ex_pcsrc,
  output logic [REG_W-1:0] ex_dst,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_MEM = 2'b10;
  localparam logic [1:0] c_FWD_WB  = 2'b01;

  // ID/EX register
  logic             r_ex_alusrc;
  logic             r_ex_regdst;
  logic [2:0]       r_ex_aluop;
  logic             r_ex_memread;
  logic             r_ex_memwrite;
  logic             r_ex_pcsrc;
  logic             r_ex_regwrite;
  logic             r_ex_memtoreg;
  logic [REG_W-1:0] r_ex_rs;
  logic [REG_W-1:0] r_ex_rt;
  logic [REG_W-1:0] r_ex_dst;

  // EX/MEM register
  logic             r_mem_regwrite;
  logic             r_mem_memtoreg;
  logic             r_mem_memread;
  logic             r_mem_memwrite;
  logic [REG_W-1:0] r_mem_dst;

  // MEM/WB register
  logic             r_wb_regwrite;
  logic             r_wb_memtoreg;
  logic [REG_W-1:0] r_wb_dst;

  // Counters
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_loaduse;
  logic             w_stall;
  logic             w_bubble;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // A taken branch in the same cycle makes the ID instruction wrong-path,
  // so the flush takes precedence and no stall is reported.
  assign w_loaduse = r_ex_memread && (r_ex_dst != '0) &&
                     ((r_ex_dst == id_rs) || (r_ex_dst == id_rt));
  assign w_stall   = w_loaduse && !ex_taken;
  assign w_bubble  = w_loaduse || ex_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_alusrc    <= 1'b0;
      r_ex_regdst    <= 1'b0;
      r_ex_aluop     <= 3'b000;
      r_ex_memread   <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_pcsrc     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memtoreg  <= 1'b0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_dst       <= '0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_dst      <= '0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_dst       <= '0;
    end else begin
      if (w_bubble) begin
        // Inserted bubble: identical to the reset state of the stage.
        r_ex_alusrc   <= 1'b0;
        r_ex_regdst   <= 1'b0;
        r_ex_aluop    <= 3'b000;
        r_ex_memread  <= 1'b0;
        r_ex_memwrite <= 1'b0;
        r_ex_pcsrc    <= 1'b0;
        r_ex_regwrite <= 1'b0;
        r_ex_memtoreg <= 1'b0;
        r_ex_rs       <= '0;
        r_ex_rt       <= '0;
        r_ex_dst      <= '0;
      end else begin
        r_ex_alusrc   <= id_alusrc;
        r_ex_regdst   <= id_regdst;
        r_ex_aluop    <= id_aluop;
        r_ex_memread  <= id_memread;
        r_ex_memwrite <= id_memwrite;
        r_ex_pcsrc    <= id_pcsrc;
        r_ex_regwrite <= id_regwrite;
        r_ex_memtoreg <= id_memtoreg;
        r_ex_rs       <= id_rs;
        r_ex_rt       <= id_rt;
        // Destination is resolved once at capture so later stages only
        // carry a single register number.
        r_ex_dst      <= id_regdst ? id_rd : id_rt;
      end

      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memtoreg <= r_ex_memtoreg;
      r_mem_memread  <= r_ex_memread;
      r_mem_memwrite <= r_ex_memwrite;
      r_mem_dst      <= r_ex_dst;

      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_dst       <= r_mem_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (ex_taken && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // Forwarding: the younger producer (EX/MEM) wins over MEM/WB, and
  // register 0 is hard-wired so it is never forwarded.
  always_comb begin
    w_fwd_a = c_FWD_RF;
    w_fwd_b = c_FWD_RF;
    if (r_mem_regwrite && (r_mem_dst != '0) && (r_mem_dst == r_ex_rs)) begin
      w_fwd_a = c_FWD_MEM;
    end else if (r_wb_regwrite && (r_wb_dst != '0) && (r_wb_dst == r_ex_rs)) begin
      w_fwd_a = c_FWD_WB;
    end
    if (r_mem_regwrite && (r_mem_dst != '0) && (r_mem_dst == r_ex_rt)) begin
      w_fwd_b = c_FWD_MEM;
    end else if (r_wb_regwrite && (r_wb_dst != '0) && (r_wb_dst == r_ex_rt)) begin
      w_fwd_b = c_FWD_WB;
    end
  end

  assign ex_alusrc    = r_ex_alusrc;
  assign ex_regdst    = r_ex_regdst;
  assign ex_aluop     = r_ex_aluop;
  assign ex_rs        = r_ex_rs;
  assign ex_rt        = r_ex_rt;
  assign ex_pcsrc     = r_ex_pcsrc;
  assign ex_dst       = r_ex_dst;
  assign mem_memread  = r_mem_memread;
  assign mem_memwrite = r_mem_memwrite;
  assign wb_regwrite  = r_wb_regwrite;
  assign wb_memtoreg  = r_wb_memtoreg;
  assign wb_dst       = r_wb_dst;
  assign fwd_a        = w_fwd_a;
  assign fwd_b        = w_fwd_b;
  assign stall        = w_stall;
  // Held low while in reset regardless of the datapath's taken flag.
  assign if_flush     = ex_taken && rst_n;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_carrier.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_carrier
// Description : Self-checking bench for pipe_ctrl_carrier. Stimulus pushes
//               hand-computed expectations tagged with the cycle they apply
//               to; a monitor compares them at each falling edge. A second
//               instance with CNT_W=4 shares all inputs to observe counter
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_carrier;

  localparam int S_EXCTL = 0;
  localparam int S_EXRS  = 1;
  localparam int S_EXDST = 2;
  localparam int S_MEM   = 3;
  localparam int S_WB    = 4;
  localparam int S_WBDST = 5;
  localparam int S_FWD   = 6;
  localparam int S_STALL = 7;
  localparam int S_FLUSH = 8;
  localparam int S_SCNT  = 9;
  localparam int S_FCNT  = 10;
  localparam int S_SAT   = 11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_alusrc, id_regdst, id_memread, id_memwrite;
  logic       id_pcsrc, id_regwrite, id_memtoreg;
  logic [2:0] id_aluop;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_taken;

  logic       ex_alusrc, ex_regdst, ex_pcsrc;
  logic [2:0] ex_aluop;
  logic [4:0] ex_rs, ex_rt, ex_dst, wb_dst;
  logic       mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, if_flush;
  logic [15:0] stall_cnt, flush_cnt;

  logic       s_ex_alusrc, s_ex_regdst, s_ex_pcsrc;
  logic [2:0] s_ex_aluop;
  logic [4:0] s_ex_rs, s_ex_rt, s_ex_dst, s_wb_dst;
  logic       s_mem_memread, s_mem_memwrite, s_wb_regwrite, s_wb_memtoreg;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic       s_stall, s_if_flush;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_ctrl_carrier #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_aluop(id_aluop),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_pcsrc(id_pcsrc),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_taken(ex_taken),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_aluop(ex_aluop),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_pcsrc(ex_pcsrc), .ex_dst(ex_dst),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .if_flush(if_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_carrier #(.REG_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_aluop(id_aluop),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_pcsrc(id_pcsrc),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_taken(ex_taken),
    .ex_alusrc(s_ex_alusrc), .ex_regdst(s_ex_regdst), .ex_aluop(s_ex_aluop),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_pcsrc(s_ex_pcsrc), .ex_dst(s_ex_dst),
    .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite),
    .wb_regwrite(s_wb_regwrite), .wb_memtoreg(s_wb_memtoreg), .wb_dst(s_wb_dst),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall), .if_flush(s_if_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_EXCTL: obs = {10'b0, ex_alusrc, ex_regdst, ex_aluop, ex_pcsrc};
      S_EXRS:  obs = {11'b0, ex_rs};
      S_EXDST: obs = {11'b0, ex_dst};
      S_MEM:   obs = {14'b0, mem_memread, mem_memwrite};
      S_WB:    obs = {14'b0, wb_regwrite, wb_memtoreg};
      S_WBDST: obs = {11'b0, wb_dst};
      S_FWD:   obs = {12'b0, fwd_a, fwd_b};
      S_STALL: obs = {15'b0, stall};
      S_FLUSH: obs = {15'b0, if_flush};
      S_SCNT:  obs = stall_cnt;
      S_FCNT:  obs = flush_cnt;
      S_SAT:   obs = {12'b0, s_stall_cnt};
      default: obs = 16'hxxxx;
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc <= cyc) begin
          logic [15:0] got;
          got = obs(q[i].sel);
          checks++;
          if (q[i].cyc < cyc) begin
            failures++;
            $display("FAIL %s missed at cycle %0d", q[i].name, q[i].cyc);
          end else if (got !== q[i].exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h",
                     q[i].name, cyc, got, q[i].exp);
          end
          q.delete(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input int sel, input logic [15:0] v,
                           input string nm);
    exp_t e;
    e.cyc = cyc + dly;
    e.sel = sel;
    e.exp = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic set_id(input logic alusrc, input logic regdst,
                        input logic [2:0] aluop, input logic memread,
                        input logic memwrite, input logic pcsrc,
                        input logic regwrite, input logic memtoreg,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    id_alusrc = alusrc;  id_regdst = regdst;  id_aluop = aluop;
    id_memread = memread; id_memwrite = memwrite; id_pcsrc = pcsrc;
    id_regwrite = regwrite; id_memtoreg = memtoreg;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic nop();
    set_id(0, 0, 3'b000, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ex_taken = 1'b0;
    nop();
    tick(); tick();

    // ---- Reset mid-stream with a live bundle (addi rs=2 rt=5) ----
    rst_n = 1'b1;
    set_id(1, 0, 3'b001, 0, 0, 0, 1, 0, 5'd2, 5'd5, 5'd0);
    tick(); tick();
    rst_n = 1'b0;
    ex_taken = 1'b1;
    expect_at(0, S_EXCTL, 16'h0, "rst_exctl");
    expect_at(0, S_EXDST, 16'h0, "rst_exdst");
    expect_at(0, S_EXRS,  16'h0, "rst_exrs");
    expect_at(0, S_MEM,   16'h0, "rst_mem");
    expect_at(0, S_WB,    16'h0, "rst_wb");
    expect_at(0, S_WBDST, 16'h0, "rst_wbdst");
    expect_at(0, S_FWD,   16'h0, "rst_fwd");
    expect_at(0, S_STALL, 16'h0, "rst_stall");
    expect_at(0, S_FLUSH, 16'h0, "rst_flush");
    expect_at(0, S_SCNT,  16'h0, "rst_scnt");
    expect_at(0, S_FCNT,  16'h0, "rst_fcnt");
    tick();
    expect_at(0, S_EXCTL, 16'h0, "rst_hold_exctl");
    expect_at(0, S_WB,    16'h0, "rst_hold_wb");
    expect_at(0, S_FLUSH, 16'h0, "rst_hold_flush");
    tick();
    rst_n = 1'b1;
    ex_taken = 1'b0;
    expect_at(0, S_EXCTL, 16'h0,        "rel_exctl_pre");
    expect_at(1, S_EXCTL, 16'b100010,   "rel_exctl");
    expect_at(1, S_EXDST, 16'd5,        "rel_exdst");
    expect_at(1, S_EXRS,  16'd2,        "rel_exrs");
    expect_at(1, S_FCNT,  16'd0,        "rel_fcnt");
    expect_at(2, S_MEM,   16'b00,       "rel_mem");
    expect_at(2, S_WB,    16'b00,       "rel_wb_early");
    expect_at(3, S_WB,    16'b10,       "rel_wb");
    expect_at(3, S_WBDST, 16'd5,        "rel_wbdst");
    tick(); tick(); tick();

    // ---- Load-use: lw rt=8 then add rs=8 rt=9 rd=10 ----
    set_id(1, 0, 3'b000, 1, 0, 0, 1, 1, 5'd1, 5'd8, 5'd0);
    tick();
    set_id(0, 1, 3'b010, 0, 0, 0, 1, 0, 5'd8, 5'd9, 5'd10);
    expect_at(0, S_STALL, 16'd1,      "lu_stall");
    expect_at(0, S_SCNT,  16'd0,      "lu_scnt_pre");
    expect_at(1, S_STALL, 16'd0,      "lu_stall_once");
    expect_at(1, S_EXCTL, 16'h0,      "lu_bubble");
    expect_at(1, S_SCNT,  16'd1,      "lu_scnt");
    expect_at(1, S_MEM,   16'b10,     "lu_mem_lw");
    expect_at(2, S_EXCTL, 16'b010100, "lu_add_ex");
    expect_at(2, S_EXDST, 16'd10,     "lu_add_dst");
    expect_at(2, S_FWD,   16'b0100,   "lu_fwd_wb");
    expect_at(2, S_WB,    16'b11,     "lu_wb_lw");
    expect_at(2, S_SCNT,  16'd1,      "lu_scnt_hold");
    tick(); tick();

    // ---- Forward priority: add d3, sub d3, and rs3 rt3 ----
    set_id(0, 1, 3'b000, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
    tick();
    set_id(0, 1, 3'b110, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
    tick();
    set_id(0, 1, 3'b100, 0, 0, 0, 1, 0, 5'd3, 5'd3, 5'd4);
    expect_at(0, S_STALL, 16'd0,    "fp_nostall");
    expect_at(1, S_FWD,   16'b1010, "fp_fwd_mem");
    tick();
    // writer to register 0, then a reader of register 0
    set_id(0, 1, 3'b000, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(0, 1, 3'b000, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd11);
    expect_at(1, S_FWD,   16'b0000, "fp_r0_nofwd");
    tick();
    nop();
    tick(); tick();

    // ---- Flush ----
    set_id(1, 0, 3'b001, 0, 0, 0, 1, 0, 5'd1, 5'd6, 5'd0);
    ex_taken = 1'b1;
    expect_at(0, S_FLUSH, 16'd1,   "fl_flush");
    expect_at(0, S_FCNT,  16'd0,   "fl_fcnt_pre");
    expect_at(1, S_EXCTL, 16'h0,   "fl_bubble");
    expect_at(1, S_FCNT,  16'd1,   "fl_fcnt");
    tick();
    ex_taken = 1'b0;
    expect_at(0, S_FLUSH, 16'd0,       "fl_flush_off");
    expect_at(1, S_EXCTL, 16'b100010,  "fl_refill");
    tick();
    nop();
    tick();

    // ---- Flush and load-use together ----
    set_id(1, 0, 3'b000, 1, 0, 0, 1, 1, 5'd1, 5'd4, 5'd0);
    tick();
    set_id(0, 1, 3'b000, 0, 0, 0, 1, 0, 5'd4, 5'd0, 5'd7);
    ex_taken = 1'b1;
    expect_at(0, S_STALL, 16'd0, "sim_nostall");
    expect_at(0, S_FLUSH, 16'd1, "sim_flush");
    expect_at(1, S_SCNT,  16'd1, "sim_scnt");
    expect_at(1, S_FCNT,  16'd2, "sim_fcnt");
    expect_at(1, S_EXCTL, 16'h0, "sim_bubble");
    tick();
    ex_taken = 1'b0;
    nop();
    tick(); tick();

    // ---- Saturation: constant lw rs8 rt8 stalls every other cycle ----
    rst_n = 1'b0;
    tick();
    set_id(1, 0, 3'b000, 1, 0, 0, 1, 1, 5'd8, 5'd8, 5'd0);
    rst_n = 1'b1;
    expect_at(0,  S_SAT,   16'd0,  "sat_start");
    expect_at(1,  S_STALL, 16'd1,  "sat_stall1");
    expect_at(2,  S_STALL, 16'd0,  "sat_gap");
    expect_at(28, S_SAT,   16'd14, "sat_14");
    expect_at(30, S_SAT,   16'd15, "sat_15");
    expect_at(40, S_SAT,   16'd15, "sat_hold");
    expect_at(40, S_SCNT,  16'd20, "sat_wide_20");
    repeat (40) tick();
    nop();
    tick(); tick(); tick();

    foreach (q[i]) begin
      failures++;
      $display("FAIL %s never compared (cycle %0d)", q[i].name, q[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
